// File: rtl/minmax_sort_sequencer_pkg.sv
// minmax_sort_pkg: shared definitions for the min/max sort sequencer.
//   sort_state_t  : controller state encoding (LOAD, SORT_ISSUE, SORT_WB, OUTPUT)
//   clog2()       : index width helper, never returns less than 1
//   compare_count : number of compare-exchanges for one block of the given depth
package minmax_sort_pkg;

  typedef enum logic [1:0] {
    LOAD       = 2'd0,
    SORT_ISSUE = 2'd1,
    SORT_WB    = 2'd2,
    OUTPUT     = 2'd3
  } sort_state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return (result == 0) ? 1 : result;
  endfunction

  // Even passes compare floor(D/2) pairs, odd passes floor((D-1)/2);
  // there are ceil(D/2) even passes and floor(D/2) odd passes.
  function automatic int compare_count(input int depth);
    return ((depth + 1) / 2) * (depth / 2) + (depth / 2) * ((depth - 1) / 2);
  endfunction

endpackage

// File: rtl/minmax_sort_sequencer_if.sv
// minmax_sort_sequencer_if: input and output valid/ready streams of the sorter.
//   InValid/InReady/InData          : unsorted word stream into the sorter
//   OutValid/OutReady/OutData/OutLast : sorted word stream out of the sorter
//   modport master : producer/consumer side (testbench or surrounding logic)
//   modport slave  : sorter side
interface minmax_sort_sequencer_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  InValid;
  logic                  InReady;
  logic [DATA_WIDTH-1:0] InData;
  logic                  OutValid;
  logic                  OutReady;
  logic [DATA_WIDTH-1:0] OutData;
  logic                  OutLast;

  modport master (
    output InValid, InData, OutReady,
    input  InReady, OutValid, OutData, OutLast
  );

  modport slave (
    input  InValid, InData, OutReady,
    output InReady, OutValid, OutData, OutLast
  );

endinterface

// File: rtl/minmax_sort_sequencer_minmax.sv
// MinMax: registered unsigned compare-exchange.
//   clk, rst_n       : clock and asynchronous active-low reset
//   a, b             : operands
//   min_val, max_val : smaller/larger operand, registered one cycle later
// Equal operands leave the order unchanged (no swap).
module MinMax #(
  parameter int INPUT_BIT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [INPUT_BIT_WIDTH-1:0] a,
  input  logic [INPUT_BIT_WIDTH-1:0] b,
  output logic [INPUT_BIT_WIDTH-1:0] min_val,
  output logic [INPUT_BIT_WIDTH-1:0] max_val
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_val <= '0;
      max_val <= '0;
    end else if (a > b) begin
      min_val <= b;
      max_val <= a;
    end else begin
      min_val <= a;
      max_val <= b;
    end
  end

endmodule

// File: rtl/minmax_sort_sequencer.sv
// minmax_sort_sequencer: loads DEPTH unsigned words, sorts them ascending with
// an odd-even transposition sort on one shared MinMax unit, streams them out.
//   Clk, ResetN : clock and asynchronous active-low reset
//   bus (slave) : input stream InValid/InReady/InData,
//                 output stream OutValid/OutReady/OutData/OutLast
//   Busy        : high whenever the controller is not in LOAD
// Optional feature: define MINMAX_SORT_EARLY_EXIT_EN to stop sorting as soon
// as an even+odd pass pair performs no swap.
module minmax_sort_sequencer
  import minmax_sort_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
) (
  input  logic                    Clk,
  input  logic                    ResetN,
  minmax_sort_sequencer_if.slave  bus,
  output logic                    Busy
);

  localparam int IDX_W      = clog2(DEPTH);
  localparam int EVEN_PAIRS = DEPTH / 2;
  localparam int ODD_PAIRS  = (DEPTH - 1) / 2;

  localparam logic [IDX_W-1:0] ONE            = IDX_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX       = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] LAST_EVEN_PAIR = IDX_W'(EVEN_PAIRS - 1);
  localparam logic [IDX_W-1:0] LAST_ODD_PAIR  = IDX_W'((ODD_PAIRS > 0) ? ODD_PAIRS - 1 : 0);

  sort_state_t           state;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      pass;
  logic [IDX_W-1:0]      pair;
  logic [IDX_W-1:0]      oidx;
  logic [DATA_WIDTH-1:0] buffer [DEPTH];

  logic                  in_ready;
  logic                  out_valid;
  logic                  out_last;
  logic                  in_fire;
  logic                  out_fire;
  logic                  last_pair;
  logic                  finish_sort;
  logic [IDX_W-1:0]      cmp_idx;
  logic [IDX_W-1:0]      cmp_idx_hi;
  logic [DATA_WIDTH-1:0] cmp_a;
  logic [DATA_WIDTH-1:0] cmp_b;
  logic [DATA_WIDTH-1:0] cmp_min;
  logic [DATA_WIDTH-1:0] cmp_max;

  assign in_fire  = bus.InValid & in_ready;
  assign out_fire = out_valid & bus.OutReady;

  // Odd passes are offset by one word: i = 2*pair + pass[0].
  assign cmp_idx    = IDX_W'({pair, 1'b0}) + IDX_W'(pass[0]);
  assign cmp_idx_hi = cmp_idx + ONE;
  assign cmp_a      = buffer[cmp_idx];
  assign cmp_b      = buffer[cmp_idx_hi];
  assign last_pair  = pass[0] ? (pair == LAST_ODD_PAIR) : (pair == LAST_EVEN_PAIR);

  MinMax #(
    .INPUT_BIT_WIDTH(DATA_WIDTH)
  ) u_minmax (
    .clk     (Clk),
    .rst_n   (ResetN),
    .a       (cmp_a),
    .b       (cmp_b),
    .min_val (cmp_min),
    .max_val (cmp_max)
  );

`ifdef MINMAX_SORT_EARLY_EXIT_EN
  // Swap flag spans one even pass plus the following odd pass; a clean odd
  // pass completion means the block is already in order.
  logic swap_seen;

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      swap_seen <= 1'b0;
    end else if (state == SORT_ISSUE) begin
      if (!pass[0] && (pair == '0)) begin
        swap_seen <= (cmp_a > cmp_b);
      end else begin
        swap_seen <= swap_seen | (cmp_a > cmp_b);
      end
    end
  end

  assign finish_sort = (pass == LAST_IDX) || (ODD_PAIRS == 0) || (pass[0] && !swap_seen);
`else
  // DEPTH=2 has an empty odd pass, so the single even pass is the whole sort.
  assign finish_sort = (pass == LAST_IDX) || (ODD_PAIRS == 0);
`endif

  // Buffer holds don't-care data after reset, so it carries no reset.
  always_ff @(posedge Clk) begin
    if (in_fire) begin
      buffer[idx] <= bus.InData;
    end else if (state == SORT_WB) begin
      buffer[cmp_idx]    <= cmp_min;
      buffer[cmp_idx_hi] <= cmp_max;
    end
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state     <= LOAD;
      idx       <= '0;
      pass      <= '0;
      pair      <= '0;
      oidx      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      Busy      <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (in_fire) begin
            idx <= idx + ONE;
            if (idx == LAST_IDX) begin
              state    <= SORT_ISSUE;
              idx      <= '0;
              pass     <= '0;
              pair     <= '0;
              in_ready <= 1'b0;
              Busy     <= 1'b1;
            end
          end
        end
        SORT_ISSUE: begin
          state <= SORT_WB;
        end
        SORT_WB: begin
          if (!last_pair) begin
            pair  <= pair + ONE;
            state <= SORT_ISSUE;
          end else if (finish_sort) begin
            state     <= OUTPUT;
            oidx      <= '0;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
          end else begin
            pass  <= pass + ONE;
            pair  <= '0;
            state <= SORT_ISSUE;
          end
        end
        OUTPUT: begin
          if (out_fire) begin
            if (out_last) begin
              state     <= LOAD;
              oidx      <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              in_ready  <= 1'b1;
              Busy      <= 1'b0;
            end else begin
              oidx     <= oidx + ONE;
              out_last <= ((oidx + ONE) == LAST_IDX);
            end
          end
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

  // OutData reads the buffer directly; it is held because neither oidx nor
  // the buffer change while a beat is stalled, and forced to 0 when idle.
  assign bus.InReady  = in_ready;
  assign bus.OutValid = out_valid;
  assign bus.OutLast  = out_last;
  assign bus.OutData  = out_valid ? buffer[oidx] : '0;

endmodule

// File: tb/tb_minmax_sort_sequencer.sv
// tb_minmax_sort_sequencer: scoreboard bench for minmax_sort_sequencer.
// One DEPTH=8 and one DEPTH=2 instance; the stimulus pushes expected beats and
// latencies into queues that per-instance monitors pop on each output beat.
// Honours MINMAX_SORT_EARLY_EXIT_EN for the expected latencies.
`timescale 1ns/1ps
module tb_minmax_sort_sequencer;
  import minmax_sort_pkg::*;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  typedef struct packed {
    logic [31:0] lat;
    logic        exact;
  } lat_t;

  localparam int LAT8 = 2 * compare_count(8);
  localparam int LAT2 = 2 * compare_count(2);
`ifdef MINMAX_SORT_EARLY_EXIT_EN
  localparam logic GEN_EXACT   = 1'b0;
  localparam int   SORTED_LAT8 = 14;
`else
  localparam logic GEN_EXACT   = 1'b1;
  localparam int   SORTED_LAT8 = LAT8;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic busy8;
  logic busy2;
  logic bp_mode = 1'b0;
  int   cycle  = 0;
  int   checks = 0;
  int   errors = 0;
  int   t0_8   = 0;
  int   t0_2   = 0;

  beat_t exp8[$];
  beat_t exp2[$];
  lat_t  lat8[$];
  lat_t  lat2[$];

  logic [7:0] din  [8];
  logic [7:0] dexp [8];

  minmax_sort_sequencer_if #(.DATA_WIDTH(8)) bus8();
  minmax_sort_sequencer_if #(.DATA_WIDTH(8)) bus2();

  minmax_sort_sequencer #(.DATA_WIDTH(8), .DEPTH(8)) u_dut8 (
    .Clk(clk), .ResetN(rst_n), .bus(bus8), .Busy(busy8)
  );

  minmax_sort_sequencer #(.DATA_WIDTH(8), .DEPTH(2)) u_dut2 (
    .Clk(clk), .ResetN(rst_n), .bus(bus2), .Busy(busy2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic logic inReady(input int sel);
    return (sel != 0) ? bus2.InReady : bus8.InReady;
  endfunction

  function automatic logic busyOf(input int sel);
    return (sel != 0) ? busy2 : busy8;
  endfunction

  task automatic setIn(input int sel, input logic valid, input logic [7:0] data);
    if (sel != 0) begin
      bus2.InValid = valid;
      bus2.InData  = data;
    end else begin
      bus8.InValid = valid;
      bus8.InData  = data;
    end
  endtask

  // Loads din[0..n-1]; Busy must rise exactly on the last handshake edge.
  task automatic applyStimulus(input int sel, input int n, input logic gap,
                               input int lat, input logic exact, input logic push);
    int w;
    for (int k = 0; k < n; k++) begin
      if (gap && k > 0) begin
        setIn(sel, 1'b0, 8'hA5);
        repeat (3) @(posedge clk);
        #1;
      end
      w = 0;
      while (!inReady(sel) && w < 500) begin
        @(posedge clk);
        #1;
        w++;
      end
      if (w >= 500) begin
        checks++;
        errors++;
        $display("[TB] FAIL in_ready_timeout: got 0, expected 1");
      end
      setIn(sel, 1'b1, din[k]);
      @(posedge clk);
      #1;
      checkOutput("busy_after_load", busyOf(sel), (k == n - 1) ? 1 : 0);
    end
    setIn(sel, 1'b0, 8'h00);
    if (sel != 0) t0_2 = cycle;
    else          t0_8 = cycle;
    if (push) begin
      for (int k = 0; k < n; k++) begin
        if (sel != 0) exp2.push_back('{data: dexp[k], last: (k == n - 1)});
        else          exp8.push_back('{data: dexp[k], last: (k == n - 1)});
      end
      if (sel != 0) lat2.push_back('{lat: lat, exact: exact});
      else          lat8.push_back('{lat: lat, exact: exact});
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((exp8.size() + exp2.size() + lat8.size() + lat2.size()) != 0 && w < 2000) begin
      @(posedge clk);
      #1;
      w++;
    end
    checkOutput("drain_pending", exp8.size() + exp2.size() + lat8.size() + lat2.size(), 0);
  endtask

  // Consumer ready for the DEPTH=8 instance: 1,0,0,1 pattern in backpressure mode.
  initial begin
    int ph;
    ph = 0;
    bus8.OutReady = 1'b1;
    bus2.OutReady = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) begin
        bus8.OutReady = (ph == 0 || ph == 3);
        ph = (ph + 1) % 4;
      end else begin
        bus8.OutReady = 1'b1;
        ph = 0;
      end
    end
  end

  // Monitor for the DEPTH=8 instance.
  initial begin
    logic       prev_valid;
    logic       stalled;
    logic       expect_ready;
    logic [7:0] held;
    beat_t      b;
    lat_t       l;
    prev_valid   = 1'b0;
    stalled      = 1'b0;
    expect_ready = 1'b0;
    held         = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid   = 1'b0;
        stalled      = 1'b0;
        expect_ready = 1'b0;
      end else begin
        if (expect_ready) begin
          checkOutput("in_ready_after_last8", bus8.InReady, 1);
          expect_ready = 1'b0;
        end
        if (bus8.OutValid) begin
          checkOutput("in_ready_during_output8", bus8.InReady, 0);
          if (!prev_valid) begin
            if (lat8.size() == 0) begin
              checks++;
              errors++;
              $display("[TB] FAIL unexpected_block8: got output, expected none");
            end else begin
              l = lat8.pop_front();
              if (l.exact) checkOutput("latency8", cycle - t0_8, l.lat);
              else         checkOutput("latency8_bound", ((cycle - t0_8) <= int'(l.lat)) ? 1 : 0, 1);
            end
          end
          if (stalled) checkOutput("stall_hold8", bus8.OutData, held);
          if (bus8.OutReady) begin
            stalled = 1'b0;
            if (exp8.size() == 0) begin
              checks++;
              errors++;
              $display("[TB] FAIL unexpected_beat8: got %0d, expected none", bus8.OutData);
            end else begin
              b = exp8.pop_front();
              checkOutput("data8", bus8.OutData, b.data);
              checkOutput("last8", bus8.OutLast, b.last);
              if (b.last) expect_ready = 1'b1;
            end
          end else begin
            stalled = 1'b1;
            held    = bus8.OutData;
          end
        end
        prev_valid = bus8.OutValid;
      end
    end
  end

  // Monitor for the DEPTH=2 instance (consumer always ready).
  initial begin
    logic  prev_valid;
    beat_t b;
    lat_t  l;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
      end else begin
        if (bus2.OutValid) begin
          if (!prev_valid) begin
            if (lat2.size() == 0) begin
              checks++;
              errors++;
              $display("[TB] FAIL unexpected_block2: got output, expected none");
            end else begin
              l = lat2.pop_front();
              checkOutput("latency2", cycle - t0_2, l.lat);
            end
          end
          if (exp2.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_beat2: got %0d, expected none", bus2.OutData);
          end else begin
            b = exp2.pop_front();
            checkOutput("data2", bus2.OutData, b.data);
            checkOutput("last2", bus2.OutLast, b.last);
          end
        end
        prev_valid = bus2.OutValid;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    setIn(0, 1'b0, 8'h00);
    setIn(1, 1'b0, 8'h00);
    rst_n = 1'b0;
    #12;
    checkOutput("reset_in_ready", bus8.InReady, 1);
    checkOutput("reset_out_valid", bus8.OutValid, 0);
    checkOutput("reset_out_last", bus8.OutLast, 0);
    checkOutput("reset_out_data", bus8.OutData, 0);
    checkOutput("reset_busy", busy8, 0);
    checkOutput("reset_in_ready2", bus2.InReady, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] basic sort");
    din  = '{8'd7, 8'd3, 8'd9, 8'd1, 8'd0, 8'd255, 8'd3, 8'd8};
    dexp = '{8'd0, 8'd1, 8'd3, 8'd3, 8'd7, 8'd8, 8'd9, 8'd255};
    applyStimulus(0, 8, 1'b0, LAT8, GEN_EXACT, 1'b1);
    drain();

    $display("[TB] output backpressure");
    bp_mode = 1'b1;
    din  = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    dexp = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    applyStimulus(0, 8, 1'b0, LAT8, GEN_EXACT, 1'b1);
    drain();
    bp_mode = 1'b0;

    $display("[TB] input gaps");
    din  = '{8'd50, 8'd40, 8'd30, 8'd20, 8'd10, 8'd60, 8'd70, 8'd5};
    dexp = '{8'd5, 8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70};
    applyStimulus(0, 8, 1'b1, LAT8, GEN_EXACT, 1'b1);
    drain();

    $display("[TB] reset mid-sort");
    din = '{8'd4, 8'd2, 8'd6, 8'd1, 8'd9, 8'd3, 8'd7, 8'd5};
    applyStimulus(0, 8, 1'b0, LAT8, GEN_EXACT, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("busy_mid_sort", busy8, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_out_valid", bus8.OutValid, 0);
    checkOutput("midreset_busy", busy8, 0);
    checkOutput("midreset_in_ready", bus8.InReady, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    din  = '{8'd200, 8'd100, 8'd150, 8'd50, 8'd250, 8'd0, 8'd25, 8'd75};
    dexp = '{8'd0, 8'd25, 8'd50, 8'd75, 8'd100, 8'd150, 8'd200, 8'd250};
    applyStimulus(0, 8, 1'b0, LAT8, GEN_EXACT, 1'b1);
    drain();

    $display("[TB] presorted input");
    din  = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    dexp = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    applyStimulus(0, 8, 1'b0, SORTED_LAT8, 1'b1, 1'b1);
    drain();

    $display("[TB] depth 2 and equal values");
    din  = '{8'd5, 8'd5, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    dexp = '{8'd5, 8'd5, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    applyStimulus(1, 2, 1'b0, LAT2, 1'b1, 1'b1);
    din  = '{8'd9, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    dexp = '{8'd2, 8'd9, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    applyStimulus(1, 2, 1'b0, LAT2, 1'b1, 1'b1);
    drain();

    repeat (2) @(posedge clk);
    #1;
    checkOutput("final_busy8", busy8, 0);
    checkOutput("final_busy2", busy2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/minmax_sort_sequencer.md
# minmax_sort_sequencer

Sequential sorter controller that time-shares a single registered min/max compare-exchange unit to sort a block of DEPTH unsigned words into ascending order. It accepts a block over a valid/ready input stream, runs an odd-even transposition sort against its internal buffer, and streams the sorted block out over a valid/ready output stream. It sits between a producer and consumer of fixed-size sample blocks, for example in median and rank filters.

## Interface
- DATA_WIDTH, 8, word width; the compare is unsigned.
- DEPTH, 8, words per block; must be ≥ 2.
- Clk  in  1  single clock; all state changes on the rising edge.
- ResetN  in  1  asynchronous, active-low reset.
- InValid  in  1  input word valid.
- InReady  out  1  sequencer accepts an input word.
- InData  in  DATA_WIDTH  input word.
- OutValid  out  1  sorted word valid.
- OutReady  in  1  consumer accepts an output word.
- OutData  out  DATA_WIDTH  sorted word.
- OutLast  out  1  marks the final word (index DEPTH-1) of the block.
- Busy  out  1  high whenever the state is not LOAD.

## Operation
- **Reset values.** Async reset forces these values immediately:
  - State is LOAD with the load index at 0.
  - InReady=1, OutValid=0, OutLast=0, OutData=0, Busy=0.
  - Buffer contents are don't-care.
- **LOAD.**
  - InReady=1.
  - Each handshake (InValid & InReady) writes InData to buf[idx] and increments idx.
  - The handshake at idx=DEPTH-1 moves to SORT_ISSUE with pass=0 and pair=0.
- **SORT_ISSUE.**
  - Drives compare A=buf[i] and B=buf[i+1], where i = 2·pair + (pass odd ? 1 : 0).
  - The compare unit registers Min and Max at the end of this cycle.
  - Next state is SORT_WB.
- **SORT_WB.**
  - Writes buf[i]=Min and buf[i+1]=Max.
  - If more pairs remain in the pass, increment pair and go to SORT_ISSUE.
  - Else, if pass=DEPTH-1, go to OUTPUT with the output index at 0.
  - Else increment pass, clear pair and go to SORT_ISSUE.
- **Pairs per pass.**
  - Even pass: floor(DEPTH/2) pairs.
  - Odd pass: floor((DEPTH-1)/2) pairs.
  - An odd pass with 0 pairs (DEPTH=2) is skipped in zero cycles.
- **OUTPUT.**
  - OutValid=1, OutData=buf[oidx], OutLast=(oidx==DEPTH-1).
  - Each handshake increments oidx.
  - The handshake with OutLast=1 returns to LOAD.
  - OutData is held stable while OutValid & !OutReady.
- **Equal values.** A==B counts as no swap; the sort is stable in value, so a duplicate ordering difference is unobservable.
- **Input during SORT/OUTPUT.** InReady=0, so no words are accepted.
- **Reset mid-operation.** Any partial load, sort or output is discarded and the block restarts in LOAD; no output beat is produced.

## Timing
- **Compare cost.** Each compare-exchange takes exactly 2 cycles (ISSUE, WB); there is no overlap between pairs.
- **Compare count.** Total compares C = ceil(DEPTH/2)·floor(DEPTH/2) + floor(DEPTH/2)·floor((DEPTH-1)/2).
  - DEPTH=8 gives C=28.
  - DEPTH=2 gives C=1.
- **Latency.**
  - The last input handshake occurs at edge t0.
  - Sort occupies cycles t0+1 … t0+2C.
  - OutValid first rises after edge t0+2C: 56 cycles for DEPTH=8, without the early-exit feature.
- **Throughput.** Output streams at one word per cycle while OutReady=1.
- **LOAD re-entry.** InReady rises the cycle after the OutLast handshake.

## Configuration
- **MINMAX_SORT_EARLY_EXIT_EN defined.**
  - A swap flag is set in SORT_ISSUE when A > B (unsigned) and cleared at the start of each even pass.
  - If an odd pass completes with the flag clear, go directly to OUTPUT.
  - A DEPTH=2 even pass with no swap goes directly to OUTPUT.
  - Latency then varies; sorted input gives 2·(floor(DEPTH/2)+floor((DEPTH-1)/2)) cycles, which is 14 for DEPTH=8.
- **Undefined.** Always runs DEPTH full passes with fixed latency 2C; no swap-flag logic is generated.

## Structure
- **Shared package minmax_sort_pkg:**
  - state encoding (LOAD, SORT_ISSUE, SORT_WB, OUTPUT);
  - a clog2 function;
  - a compare-count function C(DEPTH) used by the bench for the expected latency.
- **Compare sub-module.** One instance of the library MinMax compare-exchange (one-cycle registered Min/Max, INPUT_BIT_WIDTH=DATA_WIDTH).
- **Remaining logic.** Buffer, counters and FSM stay in minmax_sort_sequencer.

## Test plan
- **Basic sort, DEPTH=8, OutReady=1.**
  - Stimulus: load 7,3,9,1,0,255,3,8.
  - Required: output 0,1,3,3,7,8,9,255; OutLast only on 255; OutValid rises 56 cycles after the last load edge.
- **Output backpressure.**
  - Stimulus: toggle OutReady 1,0,0,1,… on a reverse-sorted input 8..1.
  - Required: outputs 1..8 with no drop or duplicate; OutData stable while stalled; InReady=0 until after the OutLast handshake.
- **Input gaps.**
  - Stimulus: InValid low for 3 cycles between loads.
  - Required: only handshaken words are stored; the sort starts exactly one cycle after the 8th handshake.
- **Reset mid-sort.**
  - Stimulus: assert ResetN=0 at cycle 20 of the sort.
  - Required: immediately OutValid=0, Busy=0, InReady=1; the next block of 8 words sorts correctly.
- **Early exit (MINMAX_SORT_EARLY_EXIT_EN).**
  - Stimulus: presorted input 1..8.
  - Required: OutValid rises 14 cycles after the last load; output 1..8.
  - Stimulus: input 8..1.
  - Required: latency ≤ 56 and output 1..8.
- **DEPTH=2 and equal values.**
  - Stimulus: load 5,5, then 9,2.
  - Required: outputs 5,5 and 2,9 respectively; sort latency 2 cycles without the macro.
